// File: rtl/dma_24b_32b_pkg.sv
// Shared frame-buffer definitions: byte-lane widths, phase encodings and padding,
// common to the write-side packer and the read-side unpacker.
package dma_24b_32b_pkg;

   localparam int unsigned PIX_W  = 24;
   localparam int unsigned WORD_W = 32;

   localparam logic [7:0] PAD_BYTE = 8'h00;

   // Pixel index within a group of 4 pixels (3 words)
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_e;

endpackage

// File: rtl/dma_24b_32b_if.sv
// Pixel-in / word-out bus of the frame-buffer write-side packer.
interface dma_24b_32b_if #(
   parameter int unsigned CNT_W = 12
);
   import dma_24b_32b_pkg::*;

   logic               dma_rst_i;
   logic               dma_de_24b_i;
   logic [PIX_W-1:0]   dma_d_24b_i;
   logic               dma_de_32b_o;
   logic [WORD_W-1:0]  dma_d_32b_o;
   logic               dma_line_done_o;
   logic [CNT_W-1:0]   dma_line_words_o;

   modport master (
      output dma_rst_i, dma_de_24b_i, dma_d_24b_i,
      input  dma_de_32b_o, dma_d_32b_o, dma_line_done_o, dma_line_words_o
   );

   modport slave (
      input  dma_rst_i, dma_de_24b_i, dma_d_24b_i,
      output dma_de_32b_o, dma_d_32b_o, dma_line_done_o, dma_line_words_o
   );

endinterface

// File: rtl/dma_line_stat.sv
// Line statistics: de falling-edge detect, saturating per-line word counter,
// line_done pulse and held line word count.
module dma_line_stat #(
   parameter int unsigned CNT_W = 12
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             de,
   input  logic             word_inc,
   output logic             line_end_c,
   output logic             line_done,
   output logic [CNT_W-1:0] line_words
);

   logic             de_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;

   assign line_end_c = de_d & ~de & ~clr;
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   // The word emitted on the line-end edge (flush) is counted into line_words
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         de_d       <= 1'b0;
         cnt_q      <= '0;
         line_done  <= 1'b0;
         line_words <= '0;
      end else if (clr) begin
         de_d      <= 1'b0;
         cnt_q     <= '0;
         line_done <= 1'b0;
      end else begin
         de_d      <= de;
         line_done <= line_end_c;
         if (line_end_c) begin
            line_words <= word_inc ? cnt_inc : cnt_q;
            cnt_q      <= '0;
         end else if (word_inc) begin
            cnt_q <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/dma_24b_32b.sv
// Write-side pixel packer: 4 x 24-bit pixels -> 3 little-endian 32-bit words.
// Define DMA_PACK_FLUSH_EN to emit a zero-padded word for leftover bytes at line end.
module dma_24b_32b
   import dma_24b_32b_pkg::*;
#(
   parameter int unsigned CNT_W = 12
) (
   input  logic           sys_clk,
   input  logic           rst_n,
   dma_24b_32b_if.slave   bus
);

   phase_e              ph_q, ph_d;
   logic [PIX_W-1:0]    res_q, res_d;
   logic                word_vld_q, word_vld_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [PIX_W-1:0]    pix;
   logic                line_end_c;
   logic                line_done;
   logic [CNT_W-1:0]    line_words;

   assign pix = bus.dma_d_24b_i;

   dma_line_stat #(.CNT_W(CNT_W)) u_stat (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .clr        (bus.dma_rst_i),
      .de         (bus.dma_de_24b_i),
      .word_inc   (word_vld_d),
      .line_end_c (line_end_c),
      .line_done  (line_done),
      .line_words (line_words)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q       <= PH0;
         res_q      <= '0;
         word_vld_q <= 1'b0;
         word_q     <= '0;
      end else begin
         ph_q       <= ph_d;
         res_q      <= res_d;
         word_vld_q <= word_vld_d;
         word_q     <= word_d;
      end
   end

   // Packing datapath; frame restart wins over a pixel, a de gap closes the line
   always_comb begin
      ph_d       = ph_q;
      res_d      = res_q;
      word_vld_d = 1'b0;
      word_d     = '0;
      if (bus.dma_rst_i) begin
         ph_d  = PH0;
         res_d = '0;
      end else if (bus.dma_de_24b_i) begin
         unique case (ph_q)
            PH0: begin
               res_d = pix;
               ph_d  = PH1;
            end
            PH1: begin
               word_vld_d = 1'b1;
               word_d     = {pix[7:0], res_q};
               res_d      = PIX_W'(pix[23:8]);
               ph_d       = PH2;
            end
            PH2: begin
               word_vld_d = 1'b1;
               word_d     = {pix[15:0], res_q[15:0]};
               res_d      = PIX_W'(pix[23:16]);
               ph_d       = PH3;
            end
            PH3: begin
               word_vld_d = 1'b1;
               word_d     = {pix, res_q[7:0]};
               res_d      = '0;
               ph_d       = PH0;
            end
         endcase
      end else if (line_end_c) begin
         ph_d  = PH0;
         res_d = '0;
`ifdef DMA_PACK_FLUSH_EN
         word_vld_d = (ph_q != PH0);
         unique case (ph_q)
            PH1:     word_d = {PAD_BYTE, res_q};
            PH2:     word_d = {{2{PAD_BYTE}}, res_q[15:0]};
            PH3:     word_d = {{3{PAD_BYTE}}, res_q[7:0]};
            default: word_d = '0;
         endcase
`endif
      end
   end

   assign bus.dma_de_32b_o     = word_vld_q;
   assign bus.dma_d_32b_o      = word_q;
   assign bus.dma_line_done_o  = line_done;
   assign bus.dma_line_words_o = line_words;

endmodule

// File: tb/tb_dma_24b_32b.sv
// Scoreboard bench for dma_24b_32b; a second instance with CNT_W=2 checks counter saturation.
module tb_dma_24b_32b;

   localparam int unsigned CNT_W  = 12;
   localparam int unsigned CNT_W2 = 2;
`ifdef DMA_PACK_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_w_t;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   exp_w_t      wq[$];
   int unsigned lq[$];
   int unsigned lq2[$];

   dma_24b_32b_if #(.CNT_W(CNT_W))  bus ();
   dma_24b_32b_if #(.CNT_W(CNT_W2)) bus2 ();

   assign bus2.dma_rst_i    = bus.dma_rst_i;
   assign bus2.dma_de_24b_i = bus.dma_de_24b_i;
   assign bus2.dma_d_24b_i  = bus.dma_d_24b_i;

   dma_24b_32b #(.CNT_W(CNT_W)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   dma_24b_32b #(.CNT_W(CNT_W2)) dut_sat (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus2)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_assert++;
      n_fail++;
      $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
   endtask

   task automatic push_w(input logic [31:0] w, input logic last);
      exp_w_t e;
      e.data = w;
      e.last = last;
      wq.push_back(e);
   endtask

   task automatic push_l(input int unsigned n);
      lq.push_back(n);
      lq2.push_back((n > 3) ? 3 : n);
   endtask

   task automatic pix(input logic [23:0] p, input logic r);
      bus.dma_de_24b_i = 1'b1;
      bus.dma_d_24b_i  = p;
      bus.dma_rst_i    = r;
      @(negedge sys_clk);
   endtask

   task automatic idle(input int n);
      bus.dma_de_24b_i = 1'b0;
      bus.dma_d_24b_i  = '0;
      bus.dma_rst_i    = 1'b0;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic line4;
      push_w(32'h66112233, 1'b0);
      push_w(32'h88994455, 1'b0);
      push_w(32'hAABBCC77, 1'b0);
      pix(24'h112233, 1'b0);
      pix(24'h445566, 1'b0);
      pix(24'h778899, 1'b0);
      pix(24'hAABBCC, 1'b0);
   endtask

   // Word / line_done monitor for the main instance
   initial begin
      exp_w_t e;
      int unsigned l;
      forever begin
         @(posedge sys_clk);
         #1;
         if (bus.dma_de_32b_o) begin
            if (wq.size() == 0) unexpected("word_unexpected", bus.dma_d_32b_o);
            else begin
               e = wq.pop_front();
               chk("word_data", bus.dma_d_32b_o, e.data);
               chk("word_done_align", 32'(bus.dma_line_done_o), 32'(e.last));
            end
         end else begin
            chk("idle_data_zero", bus.dma_d_32b_o, 32'h0);
         end
         if (bus.dma_line_done_o) begin
            if (lq.size() == 0) unexpected("line_done_unexpected", 32'(bus.dma_line_words_o));
            else begin
               l = lq.pop_front();
               chk("line_words", 32'(bus.dma_line_words_o), l);
            end
         end
      end
   end

   // line_done monitor for the saturating instance
   initial begin
      int unsigned l;
      forever begin
         @(posedge sys_clk);
         #1;
         if (bus2.dma_line_done_o) begin
            if (lq2.size() == 0) unexpected("sat_line_done_unexpected", 32'(bus2.dma_line_words_o));
            else begin
               l = lq2.pop_front();
               chk("sat_line_words", 32'(bus2.dma_line_words_o), l);
            end
         end
      end
   end

   initial begin
      int unsigned prev;
      bus.dma_rst_i    = 1'b0;
      bus.dma_de_24b_i = 1'b0;
      bus.dma_d_24b_i  = '0;
      repeat (2) @(negedge sys_clk);
      chk("rst_de_32b", 32'(bus.dma_de_32b_o), 32'h0);
      chk("rst_d_32b", bus.dma_d_32b_o, 32'h0);
      chk("rst_line_done", 32'(bus.dma_line_done_o), 32'h0);
      chk("rst_line_words", 32'(bus.dma_line_words_o), 32'h0);
      rst_n = 1'b1;
      idle(2);

      // 4-pixel line
      line4();
      push_l(3);
      idle(3);

      // 5-pixel line: one leftover pixel
      line4();
      if (FLUSH) begin
         push_w(32'h00DDEEFF, 1'b1);
         push_l(4);
      end else push_l(3);
      pix(24'hDDEEFF, 1'b0);
      idle(3);

      // 6 pixels, 1-cycle gap, 2 pixels: gap ends the first line
      line4();
      push_w(32'h03DDEEFF, 1'b0);
      if (FLUSH) begin
         push_w(32'h00000102, 1'b1);
         push_l(5);
      end else push_l(4);
      pix(24'hDDEEFF, 1'b0);
      pix(24'h010203, 1'b0);
      idle(1);
      push_w(32'h25202122, 1'b0);
      if (FLUSH) begin
         push_w(32'h00002324, 1'b1);
         push_l(2);
      end else push_l(1);
      pix(24'h202122, 1'b0);
      pix(24'h232425, 1'b0);
      idle(3);
      prev = FLUSH ? 2 : 1;

      // Frame restart together with the 3rd pixel
      push_w(32'h66112233, 1'b0);
      pix(24'h112233, 1'b0);
      pix(24'h445566, 1'b0);
      pix(24'h778899, 1'b1);
      chk("frame_rst_line_words_held", 32'(bus.dma_line_words_o), prev);
      chk("frame_rst_no_done", 32'(bus.dma_line_done_o), 32'h0);
      push_w(32'h60102030, 1'b0);
      push_w(32'h80904050, 1'b0);
      push_w(32'hA0B0C070, 1'b0);
      push_l(3);
      pix(24'h102030, 1'b0);
      pix(24'h405060, 1'b0);
      pix(24'h708090, 1'b0);
      pix(24'hA0B0C0, 1'b0);
      idle(3);

      // Asynchronous reset mid-line after 2 pixels
      push_w(32'h66112233, 1'b0);
      pix(24'h112233, 1'b0);
      pix(24'h445566, 1'b0);
      bus.dma_de_24b_i = 1'b0;
      bus.dma_d_24b_i  = '0;
      rst_n = 1'b0;
      #1;
      chk("async_de_32b", 32'(bus.dma_de_32b_o), 32'h0);
      chk("async_d_32b", bus.dma_d_32b_o, 32'h0);
      chk("async_line_done", 32'(bus.dma_line_done_o), 32'h0);
      chk("async_line_words", 32'(bus.dma_line_words_o), 32'h0);
      chk("async_sat_line_words", 32'(bus2.dma_line_words_o), 32'h0);
      repeat (2) @(negedge sys_clk);
      rst_n = 1'b1;
      idle(1);
      line4();
      push_l(3);
      idle(3);

      // 12-pixel line: 9 words, saturating instance reports 3
      line4();
      line4();
      line4();
      push_l(9);
      idle(3);

      idle(5);
      chk("words_drained", 32'(wq.size()), 32'h0);
      chk("lines_drained", 32'(lq.size()), 32'h0);
      chk("sat_lines_drained", 32'(lq2.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
